// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Processor, external and memory-side signals of the port arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, ext_ack, ext_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, ext_ack, ext_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous memory port between
//            a processor and an external loader/debug port.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  mem_port_arbiter_if.slave       bus,
  output      logic [1:0]         owner_o,
  output      logic [15:0]        cpu_wait_cycles_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic C_PORT_CPU = 1'b0;
  localparam logic C_PORT_EXT = 1'b1;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic [15:0]       wait_q, wait_d;

  logic cpu_elig;
  logic ext_elig;
  logic pick;

  assign cpu_elig = bus.cpu_req & ~bus.cpu_ack;
  assign ext_elig = bus.ext_req & ~bus.ext_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= C_PORT_EXT;
      gnt_q       <= C_PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      wait_q      <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    pick        = C_PORT_CPU;

    case (state_q)
      S_IDLE: begin
        if (cpu_elig || ext_elig) begin
          // On a tie the port that did not win last time goes first
          pick    = (cpu_elig && ext_elig) ? ~last_q : ext_elig;
          state_d = S_ACC;
          last_d  = pick;
          gnt_d   = pick;
          we_d    = pick ? bus.ext_we    : bus.cpu_we;
          addr_d  = pick ? bus.ext_addr  : bus.cpu_addr;
          wdata_d = pick ? bus.ext_wdata : bus.cpu_wdata;
        end
      end
      S_ACC: state_d = S_RESP;
      S_RESP: begin
        state_d = S_ACK;
        if (!we_q) begin
          if (gnt_q == C_PORT_EXT) ext_rdata_d = bus.mem_rdata;
          else                     cpu_rdata_d = bus.mem_rdata;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.ext_ack   = 1'b0;
    owner_o       = 2'b00;

    case (state_q)
      S_ACC: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = we_q;
        owner_o       = gnt_q ? 2'b10 : 2'b01;
      end
      S_RESP: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        owner_o       = gnt_q ? 2'b10 : 2'b01;
      end
      S_ACK: begin
        bus.cpu_ack = (gnt_q == C_PORT_CPU);
        bus.ext_ack = (gnt_q == C_PORT_EXT);
        owner_o     = gnt_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (bus.cpu_req && !bus.cpu_ack && (wait_q != 16'hFFFF))
      wait_d = wait_q + 16'd1;
  end

  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.ext_rdata    = ext_rdata_q;
  assign cpu_wait_cycles_o = wait_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  owner;
  logic [15:0] wait_cnt;
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.slave),
    .owner_o           (owner),
    .cpu_wait_cycles_o (wait_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory, contents start as addr ^ 0xB5
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Transaction-level model: an access occupies the port for 4 cycles
  int          m_busy;
  bit          m_port, m_last, m_we, m_cpu_ack, m_ext_ack;
  logic [7:0]  m_addr, m_wdata, m_cpu_rd, m_ext_rd;
  logic [15:0] m_wait;
  logic [7:0]  m_mem [256];

  task automatic model_reset();
    m_busy = 0; m_port = 0; m_last = 1; m_we = 0;
    m_addr = 0; m_wdata = 0; m_cpu_rd = 0; m_ext_rd = 0;
    m_wait = 0; m_cpu_ack = 0; m_ext_ack = 0;
  endtask

  task automatic tick();
    bit ce, ee;
    @(posedge clk);
    if (!rst) begin
      if (bus.cpu_req && !m_cpu_ack && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
      if (m_busy == 0) begin
        ce = bus.cpu_req;
        ee = bus.ext_req;
        if (ce || ee) begin
          m_port  = (ce && ee) ? !m_last : ee;
          m_last  = m_port;
          m_we    = m_port ? bus.ext_we    : bus.cpu_we;
          m_addr  = m_port ? bus.ext_addr  : bus.cpu_addr;
          m_wdata = m_port ? bus.ext_wdata : bus.cpu_wdata;
          m_busy  = 3;
        end
      end else begin
        if (m_busy == 3 && m_we) m_mem[m_addr] = m_wdata;
        if (m_busy == 2 && !m_we) begin
          if (m_port) m_ext_rd = m_mem[m_addr];
          else        m_cpu_rd = m_mem[m_addr];
        end
        m_busy--;
      end
    end
    m_cpu_ack = (m_busy == 1) && !m_port;
    m_ext_ack = (m_busy == 1) && m_port;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cpu_drive(input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic ext_drive(input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.ext_req = 1; bus.ext_we = we; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_owner got=%0h exp=0", owner); end
    checks++; if (bus.cpu_ack !== 1'b0 || bus.ext_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b%b exp=00", bus.cpu_ack, bus.ext_ack); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_bus got=%0h/%0h exp=0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cpu_rdata !== 8'h00 || bus.ext_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%0h/%0h exp=0/0", bus.cpu_rdata, bus.ext_rdata); end
    checks++; if (wait_cnt !== 16'h0000) begin errors++; $display("FAIL rst_wait got=%0h exp=0", wait_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_drive(0, 8'h10, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL cpurd_mem_we k=%0d got=%b exp=0", k, bus.mem_we); end
      checks++; if (bus.cpu_ack !== (k == 3)) begin errors++; $display("FAIL cpurd_ack k=%0d got=%b exp=%b", k, bus.cpu_ack, k == 3); end
      if (k == 3) begin
        checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL cpurd_rdata got=%0h exp=a5", bus.cpu_rdata); end
        bus.cpu_req = 0;
      end
    end
    checks++; if (wait_cnt !== 16'd3) begin errors++; $display("FAIL cpurd_wait got=%0d exp=3", wait_cnt); end
  endtask

  task automatic test_ext_write();
    do_reset();
    ext_drive(0, 8'h21, 8'h00);
    repeat (3) tick();
    checks++; if (bus.ext_ack !== 1'b1 || bus.ext_rdata !== 8'h94) begin errors++; $display("FAIL extrd got ack=%b rdata=%0h exp ack=1 rdata=94", bus.ext_ack, bus.ext_rdata); end
    bus.ext_req = 0;
    tick();
    ext_drive(1, 8'h20, 8'h5A);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (bus.mem_we !== (k == 1)) begin errors++; $display("FAIL extwr_mem_we k=%0d got=%b exp=%b", k, bus.mem_we, k == 1); end
      if (k == 1) begin
        checks++; if (bus.mem_addr !== 8'h20 || bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL extwr_bus got=%0h/%0h exp=20/5a", bus.mem_addr, bus.mem_wdata); end
      end
      checks++; if (bus.ext_ack !== (k == 3) || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL extwr_ack k=%0d got=%b%b", k, bus.cpu_ack, bus.ext_ack); end
      if (k == 3) begin
        checks++; if (bus.ext_rdata !== 8'h94) begin errors++; $display("FAIL extwr_rdata_held got=%0h exp=94", bus.ext_rdata); end
        bus.ext_req = 0;
      end
    end
    cpu_drive(0, 8'h20, 8'h00);
    repeat (3) tick();
    checks++; if (bus.cpu_rdata !== 8'h5A) begin errors++; $display("FAIL extwr_readback got=%0h exp=5a", bus.cpu_rdata); end
    bus.cpu_req = 0;
    tick();
  endtask

  task automatic test_alternate();
    int slot, ph;
    bit is_ext;
    logic [1:0] e_own;
    do_reset();
    cpu_drive(0, 8'h11, 8'h00);
    ext_drive(1, 8'h40, 8'h3C);
    for (int k = 1; k <= 16; k++) begin
      tick();
      slot   = (k - 1) / 4;
      ph     = (k - 1) % 4;
      is_ext = (slot % 2) == 1;
      e_own  = (ph == 3) ? 2'b00 : (is_ext ? 2'b10 : 2'b01);
      checks++; if (owner !== e_own) begin errors++; $display("FAIL alt_owner k=%0d got=%0h exp=%0h", k, owner, e_own); end
      checks++; if (bus.cpu_ack !== (ph == 2 && !is_ext) || bus.ext_ack !== (ph == 2 && is_ext)) begin
        errors++; $display("FAIL alt_ack k=%0d got=%b%b", k, bus.cpu_ack, bus.ext_ack); end
      checks++; if (bus.mem_we !== (ph == 0 && is_ext)) begin errors++; $display("FAIL alt_mem_we k=%0d got=%b exp=%b", k, bus.mem_we, ph == 0 && is_ext); end
    end
    checks++; if (bus.cpu_rdata !== 8'hA4) begin errors++; $display("FAIL alt_cpu_rdata got=%0h exp=a4", bus.cpu_rdata); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    cpu_drive(0, 8'h10, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (bus.cpu_ack !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, bus.cpu_ack, k % 4 == 3); end
      checks++; if (owner !== ((k % 4 == 0) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL b2b_owner k=%0d got=%0h", k, owner); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_acc();
    do_reset();
    cpu_drive(1, 8'h30, 8'hEE);
    tick();
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL racc_pre_we got=%b exp=1", bus.mem_we); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL racc_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (owner !== 2'b00 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
      errors++; $display("FAIL racc_outputs got owner=%0h addr=%0h wdata=%0h exp 0", owner, bus.mem_addr, bus.mem_wdata); end
    checks++; if (wait_cnt !== 16'h0 || bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL racc_regs got wait=%0h rdata=%0h exp 0", wait_cnt, bus.cpu_rdata); end
    bus.cpu_req = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.cpu_ack !== 1'b0 || bus.ext_ack !== 1'b0) begin errors++; $display("FAIL racc_noack k=%0d got=%b%b", k, bus.cpu_ack, bus.ext_ack); end
    end
    cpu_drive(0, 8'h30, 8'h00);
    repeat (3) tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h85) begin
      errors++; $display("FAIL racc_next got ack=%b rdata=%0h exp ack=1 rdata=85", bus.cpu_ack, bus.cpu_rdata); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [1:0] e_own;
    bit         e_acc;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      e_own = (m_busy == 0) ? 2'b00 : (m_port ? 2'b10 : 2'b01);
      e_acc = (m_busy == 3) || (m_busy == 2);
      checks++; if (owner !== e_own) begin errors++; $display("FAIL rnd_owner c=%0d got=%0h exp=%0h", c, owner, e_own); end
      checks++; if (bus.cpu_ack !== m_cpu_ack) begin errors++; $display("FAIL rnd_cpu_ack c=%0d got=%b exp=%b", c, bus.cpu_ack, m_cpu_ack); end
      checks++; if (bus.ext_ack !== m_ext_ack) begin errors++; $display("FAIL rnd_ext_ack c=%0d got=%b exp=%b", c, bus.ext_ack, m_ext_ack); end
      checks++; if (bus.cpu_rdata !== m_cpu_rd) begin errors++; $display("FAIL rnd_cpu_rdata c=%0d got=%0h exp=%0h", c, bus.cpu_rdata, m_cpu_rd); end
      checks++; if (bus.ext_rdata !== m_ext_rd) begin errors++; $display("FAIL rnd_ext_rdata c=%0d got=%0h exp=%0h", c, bus.ext_rdata, m_ext_rd); end
      checks++; if (bus.mem_we !== (m_busy == 3 && m_we)) begin errors++; $display("FAIL rnd_mem_we c=%0d got=%b exp=%b", c, bus.mem_we, m_busy == 3 && m_we); end
      checks++; if (bus.mem_addr !== (e_acc ? m_addr : 8'h00)) begin errors++; $display("FAIL rnd_mem_addr c=%0d got=%0h exp=%0h", c, bus.mem_addr, e_acc ? m_addr : 8'h00); end
      checks++; if (bus.mem_wdata !== (e_acc ? m_wdata : 8'h00)) begin errors++; $display("FAIL rnd_mem_wdata c=%0d got=%0h exp=%0h", c, bus.mem_wdata, e_acc ? m_wdata : 8'h00); end
      checks++; if (wait_cnt !== m_wait) begin errors++; $display("FAIL rnd_wait c=%0d got=%0d exp=%0d", c, wait_cnt, m_wait); end

      if (m_cpu_ack) bus.cpu_req = 0;
      else if (bus.cpu_req && m_busy == 3 && !m_port && $urandom_range(0, 7) == 0) begin
        bus.cpu_req = 0; bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
      end else if (!bus.cpu_req && $urandom_range(0, 2) == 0)
        cpu_drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));

      if (m_ext_ack) bus.ext_req = 0;
      else if (bus.ext_req && m_busy == 3 && m_port && $urandom_range(0, 7) == 0) begin
        bus.ext_req = 0; bus.ext_we = 1'($urandom_range(0, 1));
        bus.ext_addr = 8'($urandom); bus.ext_wdata = 8'($urandom);
      end else if (!bus.ext_req && $urandom_range(0, 2) == 0)
        ext_drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_wait_saturation();
    do_reset();
    cpu_drive(0, 8'h01, 8'h00);
    ext_drive(0, 8'h02, 8'h00);
    repeat (1000) tick();
    checks++; if (wait_cnt !== m_wait) begin errors++; $display("FAIL sat_mid got=%0d exp=%0d", wait_cnt, m_wait); end
    repeat (75000) tick();
    checks++; if (wait_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_top got=%0h exp=ffff", wait_cnt); end
    repeat (8) tick();
    checks++; if (wait_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_stick got=%0h exp=ffff", wait_cnt); end
    clear_inputs();
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'hB5;
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_alternate();
    test_back_to_back();
    test_reset_in_acc();
    test_random();
    test_wait_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
